// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// run_ctrl_pkg : shared types and default constants for run_ctrl
// Rev 1.0
// ----------------------------------------------------------------------
package run_ctrl_pkg;

  localparam int c_NUM_CH_DEF      = 3;
  localparam int c_CNT_W_DEF       = 32;
  localparam int c_RST_HOLD_DEF    = 4;
  localparam int c_START_DELAY_DEF = 2;

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_WAIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'b00,
    MODE_LIMIT = 2'b01,
    MODE_STEP  = 2'b10
  } mode_t;

  // The unused 2'b11 encoding behaves as free-run.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_LIMIT;
      2'b10:   return MODE_STEP;
      default: return MODE_FREE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_ctrl_sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------
// sat_counter : saturating up-counter with sticky overflow flag
// Rev 1.0
// ----------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] r_count;
  logic         r_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (inc) begin
      // An increment attempted at all-ones is the overflow event.
      if (&r_count) r_sat   <= 1'b1;
      else          r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;
  assign sat   = r_sat;

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// run_ctrl : core reset/start sequencer with free-run, limit and step modes
// Rev 1.0
// ----------------------------------------------------------------------
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CH      = c_NUM_CH_DEF,
  parameter int CNT_W       = c_CNT_W_DEF,
  parameter int RST_HOLD    = c_RST_HOLD_DEF,
  parameter int START_DELAY = c_START_DELAY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  limit,
  input  logic              step_req,
  input  logic              abort,
  input  logic [NUM_CH-2:0] btn_in,
  output logic              core_rst_n,
  output logic              core_en,
  output logic [NUM_CH-1:0] ch_out,
  output logic [CNT_W-1:0]  cycle,
  output logic              running,
  output logic              done,
  output logic              overflow
);

  localparam int c_HOLD_W = $clog2(RST_HOLD) + 1;
  localparam int c_WAIT_W = $clog2(START_DELAY) + 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RST_HOLD - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST =
    c_WAIT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  state_t              r_state, w_state_nxt, w_start;
  mode_t               r_mode, w_mode_nxt, w_mode_in;
  logic [c_HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic                r_abort_pend, w_abort_pend_nxt;
  logic                r_core_rst_n, r_core_en, r_running, r_done;
  logic [NUM_CH-1:0]   r_ch_out;
  logic                w_active, w_core_en_nxt, w_limit_hit;
  logic [CNT_W:0]      w_cnt_plus;

  // Decided one edge early so the counter lands on limit as the enable drops.
  assign w_cnt_plus  = {1'b0, cycle} + (CNT_W + 1)'(1);
  assign w_limit_hit = (w_cnt_plus >= {1'b0, limit});

  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold_cnt;
    w_wait_nxt       = r_wait_cnt;
    w_mode_nxt       = r_mode;
    w_abort_pend_nxt = r_abort_pend;
    w_mode_in        = decode_mode(mode);

    case (w_mode_in)
      MODE_STEP:  w_start = ST_STEP;
      MODE_LIMIT: w_start = (limit == '0) ? ST_DONE : ST_RUN;
      default:    w_start = ST_RUN;
    endcase

    case (r_state)
      ST_HOLD: begin
        if (abort) w_abort_pend_nxt = 1'b1;
        if (r_hold_cnt == c_HOLD_LAST) begin
          if (r_abort_pend || abort) begin
            w_state_nxt = ST_DONE;
          end else if (START_DELAY == 0) begin
            w_state_nxt = w_start;
            w_mode_nxt  = w_mode_in;
          end else begin
            w_state_nxt = ST_WAIT;
            w_wait_nxt  = '0;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_state_nxt = ST_DONE;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_state_nxt = w_start;
          w_mode_nxt  = w_mode_in;
        end else begin
          w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
        end
      end
      ST_RUN: begin
        if (abort || (r_mode == MODE_LIMIT && w_limit_hit)) w_state_nxt = ST_DONE;
      end
      ST_STEP: begin
        if (abort) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_HOLD;
    endcase

    w_active      = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_STEP);
    // Requests count only when already in STEP and staying there.
    w_core_en_nxt = (w_state_nxt == ST_RUN) ||
                    ((r_state == ST_STEP) && (w_state_nxt == ST_STEP) && step_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_HOLD;
      r_mode       <= MODE_FREE;
      r_hold_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_abort_pend <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_core_en    <= 1'b0;
      r_ch_out     <= '0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_abort_pend <= w_abort_pend_nxt;
      r_core_rst_n <= (w_state_nxt != ST_HOLD);
      r_core_en    <= w_core_en_nxt;
      r_ch_out     <= w_active ? {btn_in, 1'b1} : '0;
      r_running    <= w_active;
      r_done       <= (w_state_nxt == ST_DONE);
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (r_core_en),
    .count(cycle),
    .sat  (overflow)
  );

  assign core_rst_n = r_core_rst_n;
  assign core_en    = r_core_en;
  assign ch_out     = r_ch_out;
  assign running    = r_running;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_run_ctrl : directed self-checking bench for run_ctrl
// Rev 1.0
// ----------------------------------------------------------------------
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [31:0] limit;
  logic [3:0]  limit4;
  logic        step_req;
  logic        abort;
  logic [1:0]  btn_in;

  logic        core_rst_n, core_en, running, done, overflow;
  logic [2:0]  ch_out;
  logic [31:0] cycle;
  logic        core_rst_n4, core_en4, running4, done4, overflow4;
  logic [2:0]  ch_out4;
  logic [3:0]  cycle4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  run_ctrl u_dut (
    .clk(clk), .rst(rst), .mode(mode), .limit(limit), .step_req(step_req),
    .abort(abort), .btn_in(btn_in), .core_rst_n(core_rst_n), .core_en(core_en),
    .ch_out(ch_out), .cycle(cycle), .running(running), .done(done),
    .overflow(overflow)
  );

  run_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .limit(limit4), .step_req(step_req),
    .abort(abort), .btn_in(btn_in), .core_rst_n(core_rst_n4), .core_en(core_en4),
    .ch_out(ch_out4), .cycle(cycle4), .running(running4), .done(done4),
    .overflow(overflow4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Starts just after the last reset edge; ends one edge before the start state.
  task automatic startup_checks();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rst_n", core_rst_n, 0);
      chk("hold_en", core_en, 0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wait_rst_n", core_rst_n, 1);
      chk("wait_en", core_en, 0);
      chk("wait_ch", ch_out, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    int          pulses;
    int          exp4;

    rst = 1'b1; mode = 2'b00; limit = '0; limit4 = '0;
    step_req = 1'b0; abort = 1'b0; btn_in = '0;

    // Free-run, both counter widths
    reset_seq();
    chk("rst_rst_n", core_rst_n, 0);
    chk("rst_en", core_en, 0);
    chk("rst_ch", ch_out, 0);
    chk("rst_cycle", cycle, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ovf4", overflow4, 0);
    startup_checks();
    for (int k = 1; k <= 20; k++) begin
      btn_in = 2'(k);
      tick();
      exp4 = (k - 1 > 15) ? 15 : k - 1;
      chk("free_en", core_en, 1);
      chk("free_ch", ch_out, {2'(k), 1'b1});
      chk("free_cycle", cycle, 64'(k - 1));
      chk("free_cycle4", cycle4, 64'(exp4));
      chk("free_ovf4", overflow4, (k - 1 >= 16) ? 1 : 0);
      chk("free_ovf", overflow, 0);
    end

    // Cycle-limited run
    mode = 2'b01; limit = 32'd10;
    reset_seq();
    startup_checks();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_en) pulses++;
    end
    chk("lim_pulses", 64'(pulses), 10);
    chk("lim_done", done, 1);
    chk("lim_cycle", cycle, 10);
    chk("lim_running", running, 0);
    chk("lim_ch", ch_out, 0);
    chk("lim_rst_n", core_rst_n, 1);

    // Single-step: requests during startup are ignored
    mode = 2'b10; limit = '0; btn_in = '0;
    reset_seq();
    step_req = 1'b1;
    startup_checks();
    tick();
    chk("step_entry_en", core_en, 0);
    chk("step_running", running, 1);
    chk("step_ch0", ch_out[0], 1);
    pat = 16'b0000_0110_1000_1001;
    for (int i = 0; i < 16; i++) begin
      step_req = pat[i];
      tick();
      chk("step_en", core_en, pat[i]);
    end
    step_req = 1'b0;
    chk("step_cycle", cycle, 5);

    // Abort wins over a simultaneous step request
    abort = 1'b1; step_req = 1'b1;
    tick();
    abort = 1'b0; step_req = 1'b0;
    chk("ab_step_done", done, 1);
    chk("ab_step_en", core_en, 0);
    chk("ab_step_running", running, 0);
    tick();
    chk("ab_step_en2", core_en, 0);
    chk("ab_step_cycle", cycle, 5);

    // Abort during hold completes the hold first
    mode = 2'b00;
    reset_seq();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_hold_rst_n1", core_rst_n, 0);
    chk("ab_hold_done1", done, 0);
    tick();
    tick();
    chk("ab_hold_rst_n3", core_rst_n, 0);
    chk("ab_hold_done3", done, 0);
    tick();
    chk("ab_hold_done", done, 1);
    chk("ab_hold_rst_n", core_rst_n, 1);
    chk("ab_hold_en", core_en, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("ab_hold_en_late", core_en, 0);
    chk("ab_hold_cycle", cycle, 0);

    // Reset in the middle of a run
    btn_in = 2'b11;
    reset_seq();
    startup_checks();
    for (int i = 0; i < 8; i++) tick();
    chk("mid_cycle7", cycle, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_cycle", cycle, 0);
    chk("mid_en", core_en, 0);
    chk("mid_ch", ch_out, 0);
    chk("mid_rst_n", core_rst_n, 0);
    chk("mid_running", running, 0);
    startup_checks();
    tick();
    chk("mid_restart_en", core_en, 1);
    chk("mid_restart_cycle", cycle, 0);
    chk("mid_restart_ch", ch_out, 3'b111);

    // Zero budget goes straight to done
    mode = 2'b01; limit = '0;
    reset_seq();
    for (int i = 0; i < 6; i++) tick();
    chk("lim0_done", done, 1);
    chk("lim0_en", core_en, 0);
    chk("lim0_running", running, 0);
    chk("lim0_cycle", cycle, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3: number of front-panel channel outputs (channel 0 is the run-enable, e.g. CH).
REQ-002 The block SHALL have parameter CNT_W, default 32: cycle counter width.
REQ-003 The block SHALL have parameter RST_HOLD, default 4: number of cycles the core reset is held (minimum 1).
REQ-004 The block SHALL have parameter START_DELAY, default 2: number of cycles between core reset release and run start (0 allowed).
REQ-005 The block SHALL have port clk, input, 1: system clock.
REQ-006 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 The block SHALL have port mode, input, 2: 00 free-run, 01 cycle-limited, 10 single-step, 11 treated as 00.
REQ-008 The block SHALL have port limit, input, CNT_W: cycle budget in mode 01.
REQ-009 The block SHALL have port step_req, input, 1: single-cycle step request in mode 10.
REQ-010 The block SHALL have port abort, input, 1: force stop.
REQ-011 The block SHALL have port btn_in, input, NUM_CH-1: raw requests for channels 1..NUM_CH-1.
REQ-012 The block SHALL have port core_rst_n, output, 1: active-low reset to the processor core.
REQ-013 The block SHALL have port core_en, output, 1: clock enable to the core.
REQ-014 The block SHALL have port ch_out, output, NUM_CH: channel levels to the core.
REQ-015 The block SHALL have port cycle, output, CNT_W: count of enabled core cycles.
REQ-016 The block SHALL have port running, output, 1: high while in state RUN or STEP.
REQ-017 The block SHALL have port done, output, 1: high in state DONE.
REQ-018 The block SHALL have port overflow, output, 1: sticky flag set on cycle counter saturation.

Function
REQ-019 The block SHALL implement the states HOLD, WAIT, RUN, STEP and DONE, with all outputs registered.
REQ-020 HOLD SHALL drive core_rst_n=0 for exactly RST_HOLD cycles, then transition to WAIT.
REQ-021 WAIT SHALL drive core_rst_n=1 and core_en=0 for START_DELAY cycles.
REQ-022 On WAIT exit, mode SHALL be latched and never resampled until rst.
REQ-023 On WAIT exit with mode 10 the block SHALL enter STEP; with mode 01 and limit=0 it SHALL enter DONE; otherwise it SHALL enter RUN.
REQ-024 ch_out[0] SHALL be 1 in RUN and STEP, and 0 in all other states.
REQ-025 ch_out[k] for k≥1 SHALL equal btn_in[k-1] delayed one register while in RUN or STEP, and 0 otherwise.
REQ-026 RUN SHALL drive core_en=1 on every cycle.
REQ-027 cycle SHALL increment on each cycle where core_en=1 and SHALL saturate at 2^CNT_W-1.
REQ-028 overflow SHALL set on the increment attempt at the saturated value and SHALL stay set until rst.
REQ-029 In mode 01, when cycle reaches limit the block SHALL transition to DONE, with core_en low the same cycle, so exactly limit enabled cycles occur.
REQ-030 In STEP, each step_req=1 cycle SHALL yield exactly one core_en=1 cycle one clock later; back-to-back requests SHALL yield back-to-back enables.
REQ-031 abort=1 in any state other than DONE SHALL force DONE on the next cycle; abort SHALL win over a simultaneous step_req or limit hit.
REQ-032 In HOLD, abort SHALL still complete the reset hold before entering DONE.
REQ-033 DONE SHALL drive core_en=0, done=1 and core_rst_n=1, and SHALL hold cycle until rst.
REQ-034 step_req outside STEP SHALL be ignored.

Reset
REQ-035 rst SHALL force state HOLD with its hold counter cleared.
REQ-036 rst SHALL drive core_rst_n=0, core_en=0, ch_out=0, cycle=0, running=0, done=0 and overflow=0 on the next edge.
REQ-037 rst asserted mid-RUN or mid-STEP SHALL restart the full sequence, with no residual enable.

Structure
REQ-038 Package run_ctrl_pkg SHALL define the state enum, the mode enum (MODE_FREE, MODE_LIMIT, MODE_STEP), and the default parameter constants.
REQ-039 Sub-module sat_counter (parameter W; inputs clk, rst, inc; outputs count, sat) SHALL implement the cycle counter and the overflow flag.
REQ-040 The hold and delay counters SHALL be sized with $clog2 of their parameters plus 1.

Verification
REQ-041 rst for 2 cycles, mode=00, defaults -> core_rst_n low 4 cycles, then 2 cycles of core_en=0, then ch_out[0]=1 and core_en=1 continuously, with cycle counting 1,2,3,...
REQ-042 mode=01, limit=10 -> exactly 10 core_en pulses, then done=1, cycle=10 held, running=0.
REQ-043 mode=10, step_req pulses at three separate cycles plus one 2-cycle burst -> exactly 5 core_en cycles, each one clock after its request, and cycle=5.
REQ-044 CNT_W=4, mode=00, run 20 cycles -> cycle saturates at 15, overflow=1 from the 16th enabled cycle onward.
REQ-045 abort coincident with step_req in STEP, and separately abort during HOLD -> no extra core_en; DONE is entered next cycle (STEP) or after the hold completes (HOLD).
REQ-046 rst asserted mid-RUN at cycle=7 -> next edge cycle=0, core_en=0, ch_out=0, and the full HOLD/WAIT sequence repeats.
